// File: rtl/bios_loader.sv
// Streams a BIOS image into the external SRAM BIOS window, then exposes that window to the CPU as ROM.
// Optional image checksum check is enabled by defining BIOS_LOADER_CHECKSUM_EN.
module bios_loader #(
  parameter logic [15:0] BIOS_BASE = 16'h0000,
  parameter int unsigned BIOS_SIZE = 65536
) (
  input  logic        clka,
  input  logic        reset_n,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  input  logic        cpu_ena,
  input  logic        cpu_wea,
  input  logic [15:0] cpu_addr,
  output logic [7:0]  cpu_douta,
  output logic        bios_ena,
  output logic        bios_wea,
  output logic [15:0] bios_addra,
  output logic [7:0]  bios_dina,
  input  logic [7:0]  bios_douta,
  output logic        busy,
  output logic        done,
  output logic [16:0] byte_count,
  output logic        checksum_ok
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [16:0] IMAGE_BYTES = 17'(BIOS_SIZE);

  state_t      state;
  state_t      next_state;
  logic [15:0] addr;
  logic [16:0] count;
  logic [7:0]  data_q;
  logic        start_load;
  logic        accept;
  logic        last_byte;

  // A load may only be (re)started from IDLE or DONE; mid-load pulses are dropped.
  assign start_load = start && ((state == IDLE) || (state == DONE));
  assign accept     = (state == LOAD) && s_valid;
  assign last_byte  = (count + 17'd1) == IMAGE_BYTES;
  assign byte_count = count;

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_load) next_state = LOAD;
      LOAD:    if (accept) next_state = WRITE;
      WRITE:   next_state = last_byte ? DONE : LOAD;
      DONE:    if (start_load) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  // Address and count advance as the WRITE cycle ends, so the write itself sees the pre-increment values.
  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      addr   <= BIOS_BASE;
      count  <= 17'd0;
      data_q <= 8'h00;
    end else if (start_load) begin
      addr  <= BIOS_BASE;
      count <= 17'd0;
    end else if (accept) begin
      data_q <= s_data;
    end else if (state == WRITE) begin
      addr  <= addr + 16'd1;
      count <= count + 17'd1;
    end
  end

`ifdef BIOS_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      sum <= 8'h00;
    end else if (start_load) begin
      sum <= 8'h00;
    end else if (accept) begin
      sum <= sum + s_data;
    end
  end

  assign checksum_ok = (state == DONE) && (sum == 8'h00);
`else
  assign checksum_ok = done;
`endif

  // In DONE the port is a combinational pass-through for CPU reads; the CPU write request is masked off.
  always_comb begin
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    bios_ena   = 1'b0;
    bios_wea   = 1'b0;
    bios_addra = addr;
    bios_dina  = data_q;
    cpu_douta  = 8'hFF;
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      WRITE: begin
        busy     = 1'b1;
        bios_ena = 1'b1;
        bios_wea = 1'b1;
      end
      DONE: begin
        done       = 1'b1;
        bios_ena   = cpu_ena;
        bios_wea   = cpu_wea & 1'b0;
        bios_addra = cpu_addr;
        cpu_douta  = bios_douta;
      end
      default: begin
        s_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bios_loader.sv
// Scoreboarded bench for bios_loader: random byte streams, a behavioural SRAM and an image reference model.
module tb_bios_loader;

  localparam logic [15:0] BASE = 16'hFFFE;
  localparam int          SIZE = 4;

  logic        clka = 1'b0;
  logic        reset_n;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        cpu_ena;
  logic        cpu_wea;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_douta;
  logic        bios_ena;
  logic        bios_wea;
  logic [15:0] bios_addra;
  logic [7:0]  bios_dina;
  logic [7:0]  bios_douta;
  logic        busy;
  logic        done;
  logic [16:0] byte_count;
  logic        checksum_ok;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          idx;
  } wr_t;

  wr_t        expq[$];
  int         checks = 0;
  int         passes = 0;
  int         loadIdx = 0;
  logic [7:0] image[0:SIZE-1];
  logic [7:0] sram[0:65535];
  logic [7:0] stim[0:SIZE-1];

  bios_loader #(.BIOS_BASE(BASE), .BIOS_SIZE(SIZE)) dut (
    .clka(clka), .reset_n(reset_n), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cpu_ena(cpu_ena), .cpu_wea(cpu_wea), .cpu_addr(cpu_addr), .cpu_douta(cpu_douta),
    .bios_ena(bios_ena), .bios_wea(bios_wea), .bios_addra(bios_addra),
    .bios_dina(bios_dina), .bios_douta(bios_douta),
    .busy(busy), .done(done), .byte_count(byte_count), .checksum_ok(checksum_ok)
  );

  always #5 clka = ~clka;

  // SRAM samples on the falling edge, like the real BIOS port.
  always @(negedge clka) begin
    if (bios_ena && bios_wea) sram[bios_addra] <= bios_dina;
  end

  assign bios_douta = sram[bios_addra];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Every write pulse must match the oldest byte the driver handed over.
  always @(negedge clka) begin
    wr_t e;
    if (reset_n === 1'b1 && bios_ena === 1'b1 && bios_wea === 1'b1) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_write", 32'(bios_addra), 32'hFFFF_FFFF);
      end else begin
        e = expq.pop_front();
        checkOutput("write_addr", 32'(bios_addra), 32'(e.addr));
        checkOutput("write_data", 32'(bios_dina), 32'(e.data));
        checkOutput("write_byte_count", 32'(byte_count), 32'(e.idx));
        checkOutput("ready_low_in_write", 32'(s_ready), 32'd0);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input int gap);
    int w;
    repeat (gap) begin
      @(negedge clka);
      s_valid = 1'b0;
    end
    @(negedge clka);
    s_valid = 1'b1;
    s_data  = d;
    w = 0;
    while (!s_ready && w < 20) begin
      @(negedge clka);
      w++;
    end
    if (!s_ready) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      s_valid = 1'b0;
      return;
    end
    expq.push_back('{addr: 16'(BASE + loadIdx), data: d, idx: loadIdx});
    image[loadIdx] = d;
    loadIdx++;
    @(negedge clka);
    s_valid = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge clka);
    start = 1'b1;
    @(negedge clka);
    start = 1'b0;
  endtask

  task automatic runLoad(input bit doStart, input bit midStart);
    int sum;
    loadIdx = 0;
    sum = 0;
    if (doStart) pulseStart();
    for (int i = 0; i < SIZE; i++) begin
      applyStimulus(stim[i], int'($urandom_range(0, 3)));
      sum += int'(stim[i]);
      if (midStart && i == 1) begin
        start = 1'b1;
        @(negedge clka);
        start = 1'b0;
        checkOutput("busy_after_mid_start", 32'(busy), 32'd1);
        pulseStart();
      end
    end
    checkOutput("done_during_last_write", 32'(done), 32'd0);
    @(negedge clka);
    checkOutput("done", 32'(done), 32'd1);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("final_byte_count", 32'(byte_count), 32'(SIZE));
`ifdef BIOS_LOADER_CHECKSUM_EN
    checkOutput("checksum_ok", 32'(checksum_ok), 32'((sum % 256) == 0));
`else
    checkOutput("checksum_ok", 32'(checksum_ok), 32'd1);
`endif
    checkOutput("all_writes_seen", 32'(expq.size()), 32'd0);
  endtask

  task automatic cpuReadImage();
    for (int i = 0; i < SIZE; i++) begin
      @(negedge clka);
      cpu_ena  = 1'b1;
      cpu_wea  = 1'b0;
      cpu_addr = 16'(BASE + i);
      #1;
      checkOutput("cpu_read_data", 32'(cpu_douta), 32'(image[i]));
    end
    cpu_ena = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] acc;
    reset_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    cpu_ena = 1'b0; cpu_wea = 1'b0; cpu_addr = 16'h0000;
    repeat (3) @(negedge clka);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_bios_ena", 32'(bios_ena), 32'd0);
    checkOutput("rst_bios_wea", 32'(bios_wea), 32'd0);
    checkOutput("rst_bios_addra", 32'(bios_addra), 32'(BASE));
    checkOutput("rst_bios_dina", 32'(bios_dina), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_byte_count", 32'(byte_count), 32'd0);
    checkOutput("rst_cpu_douta", 32'(cpu_douta), 32'hFF);
    checkOutput("rst_checksum_ok", 32'(checksum_ok), 32'd0);
    reset_n = 1'b1;

    // Stream valid and CPU strobes in IDLE must be ignored.
    s_valid = 1'b1; s_data = 8'h5A; cpu_ena = 1'b1; cpu_wea = 1'b1;
    repeat (4) @(negedge clka);
    checkOutput("idle_ready", 32'(s_ready), 32'd0);
    checkOutput("idle_cpu_blocked", 32'(bios_ena), 32'd0);
    checkOutput("idle_cpu_douta", 32'(cpu_douta), 32'hFF);
    s_valid = 1'b0; cpu_ena = 1'b0; cpu_wea = 1'b0;

    stim = '{8'h10, 8'h20, 8'h30, 8'hA0};
    runLoad(1'b1, 1'b0);
    cpuReadImage();
    @(negedge clka);
    cpu_ena = 1'b1; cpu_wea = 1'b1; cpu_addr = 16'h0002;
    #1;
    checkOutput("rom_wea_masked", 32'(bios_wea), 32'd0);
    checkOutput("rom_addra", 32'(bios_addra), 32'h0002);
    checkOutput("rom_ena", 32'(bios_ena), 32'd1);
    cpu_ena = 1'b0; cpu_wea = 1'b0;

    stim = '{8'h10, 8'h20, 8'h30, 8'hA1};
    runLoad(1'b1, 1'b0);
    cpuReadImage();

    // Reset after two bytes of a four-byte load.
    loadIdx = 0;
    pulseStart();
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 1);
    @(negedge clka);
    #2 reset_n = 1'b0;
    cpu_ena = 1'b1; cpu_addr = BASE;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_byte_count", 32'(byte_count), 32'd0);
    checkOutput("midrst_bios_ena", 32'(bios_ena), 32'd0);
    checkOutput("midrst_cpu_douta", 32'(cpu_douta), 32'hFF);
    @(negedge clka);
    reset_n = 1'b1;
    cpu_ena = 1'b0;

    // Random image with mid-load start pulses (one in WRITE, one in LOAD).
    for (int i = 0; i < SIZE; i++) stim[i] = 8'($urandom);
    runLoad(1'b1, 1'b1);
    cpuReadImage();

    // Zero-sum random image; its start coincides with a CPU read in DONE.
    acc = 8'h00;
    for (int i = 0; i < SIZE - 1; i++) begin
      stim[i] = 8'($urandom);
      acc = acc + stim[i];
    end
    stim[SIZE-1] = 8'h00 - acc;
    @(negedge clka);
    cpu_ena = 1'b1; cpu_addr = BASE; start = 1'b1;
    #1;
    checkOutput("coincide_read_before", 32'(cpu_douta), 32'(image[0]));
    @(negedge clka);
    start = 1'b0;
    checkOutput("coincide_read_after", 32'(cpu_douta), 32'hFF);
    checkOutput("coincide_busy", 32'(busy), 32'd1);
    cpu_ena = 1'b0;
    runLoad(1'b0, 1'b0);
    cpuReadImage();

    repeat (3) @(negedge clka);
    checkOutput("no_stray_writes", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
